// File: rtl/alu_pwr_pkg.sv
// Shared types and defaults for the ALU clock-gate controller.
// Imported by the controller top and its saturating counters.
package alu_pwr_pkg;

    typedef enum logic [1:0] {
        SLEEP  = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2
    } pwr_state_t;

    localparam int OP_W_DEF  = 4;
    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/alu_pwr_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// The clear input wins over the increment input.
module alu_pwr_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_gate_ctrl.sv
// Enable controller for the ALU clock-gating cell.
// Wakes the gated clock ahead of issue and sleeps after an idle interval.
module alu_gate_ctrl
    import alu_pwr_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req_Valid,
    input  logic [OP_W-1:0]  Req_Op,
    output logic             Req_Ready,
    input  logic             Busy,
    input  logic             Force_On,
    input  logic             Cnt_Clr,
    output logic             Enable,
    output logic             Alu_Start,
    output logic [OP_W-1:0]  Alu_Op,
    output logic [CNT_W-1:0] Gated_Cnt,
    output logic [CNT_W-1:0] Active_Cnt
);

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

    pwr_state_t state;
    pwr_state_t state_nxt;
    logic [7:0] idle_cnt;
    logic [7:0] idle_nxt;
    logic [3:0] wake_cnt;
    logic [3:0] wake_nxt;
    logic       accept;
    logic       activity;

    // Ready depends on state only, never on Req_Valid.
    assign Req_Ready = (state == ACTIVE);
    assign accept    = Req_Valid & Req_Ready;
    assign activity  = Req_Valid | Busy | Force_On | Alu_Start;

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        unique case (state)
            SLEEP: begin
                idle_nxt = '0;
                wake_nxt = '0;
                if (Req_Valid | Busy | Force_On) begin
                    state_nxt = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    wake_nxt  = '0;
                    idle_nxt  = '0;
                    state_nxt = ACTIVE;
                end else begin
                    wake_nxt = wake_cnt + 4'd1;
                end
            end
            ACTIVE: begin
                if (activity) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    idle_nxt  = '0;
                    state_nxt = SLEEP;
                end else begin
                    idle_nxt = idle_cnt + 8'd1;
                end
            end
            default: begin
                idle_nxt  = '0;
                wake_nxt  = '0;
                state_nxt = SLEEP;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= SLEEP;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    // Enable tracks the next state so it leads the state register by nothing.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Enable    <= 1'b0;
            Alu_Start <= 1'b0;
            Alu_Op    <= '0;
        end else begin
            Enable    <= (state_nxt != SLEEP);
            Alu_Start <= accept;
            if (accept) begin
                Alu_Op <= Req_Op;
            end
        end
    end

    alu_pwr_sat_cnt #(
        .W (CNT_W)
    ) u_gated_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (~Enable),
        .clr   (Cnt_Clr),
        .q     (Gated_Cnt)
    );

    alu_pwr_sat_cnt #(
        .W (CNT_W)
    ) u_active_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (Enable),
        .clr   (Cnt_Clr),
        .q     (Active_Cnt)
    );

endmodule

// File: doc/alu_gate_ctrl.md
# alu_gate_ctrl

Clock-gate enable controller that sits directly upstream of the ALU clock-gating cell and drives that cell's `Enable` input. It accepts ALU operation requests over a valid/ready handshake. It wakes the gated ALU clock ahead of issuing each request and holds it running while work is pending. After a programmable idle interval it drops the enable. Two saturating counters report gated and active cycles for power-measurement runs.

## Interface
Parameters:
- `OP_W`, 4: width of ALU opcode.
- `IDLE_CYCLES`, 8: consecutive idle cycles in ACTIVE before sleeping; legal range 1..255.
- `WAKE_CYCLES`, 1: cycles spent in WAKE before accepting requests; legal range 1..15.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `Clk` in 1: free-running clock (ungated).
- `Rst_n` in 1: asynchronous active-low reset.
- `Req_Valid` in 1: upstream request valid; held stable until accepted.
- `Req_Op` in OP_W: requested opcode.
- `Req_Ready` out 1: controller can accept a request.
- `Busy` in 1: ALU multi-cycle operation in progress; blocks sleep.
- `Force_On` in 1: keep the gated clock running unconditionally.
- `Cnt_Clr` in 1: synchronous clear of both statistics counters.
- `Enable` out 1: to the clock-gating cell's `Enable` input.
- `Alu_Start` out 1: one-cycle issue pulse to the ALU.
- `Alu_Op` out OP_W: opcode issued with `Alu_Start`.
- `Gated_Cnt` out CNT_W: cycles with `Enable`=0, saturating.
- `Active_Cnt` out CNT_W: cycles with `Enable`=1, saturating.

## Operation
- States: SLEEP, WAKE, ACTIVE.
- SLEEP:
  - `Enable`=0, `Req_Ready`=0.
  - `Req_Valid|Busy|Force_On` → WAKE.
- WAKE:
  - `Enable`=1, `Req_Ready`=0.
  - Wake counter counts `WAKE_CYCLES` cycles, then → ACTIVE.
  - Wake time covers the gating cell's one-cycle enable latch.
- ACTIVE:
  - `Enable`=1, `Req_Ready`=1.
  - Accept = `Req_Valid & Req_Ready`.
  - Activity = `Req_Valid | Busy | Force_On | Alu_Start`.
  - Idle counter clears on activity and increments otherwise.
  - Idle counter == `IDLE_CYCLES-1` with no activity → SLEEP.
- Expiry and request in the same cycle: the request is accepted and the state stays ACTIVE.
- `Busy` or `Force_On` held high keeps the state in ACTIVE indefinitely.
- Issue register:
  - On accept, `Alu_Start`=1 and `Alu_Op`=`Req_Op` for exactly the next cycle.
  - `Alu_Op` holds its last value otherwise.
  - Back-to-back accepts produce back-to-back pulses, giving throughput of 1 op/cycle.
- Counters:
  - Saturate at all-ones.
  - `Cnt_Clr` has priority and loads 0; counting resumes on the following cycle.
- Reset, including reset asserted mid-operation:
  - Outputs: SLEEP, `Enable`=0, `Alu_Start`=0, `Alu_Op`=0, both counters 0.
  - Internal: idle and wake counters 0.
  - An in-flight request is dropped; upstream re-presents it.

## Timing
- `Enable`, `Alu_Start`, `Alu_Op` and the counters are registered. `Req_Ready` is decoded from state only, with no combinational path from `Req_Valid`.
- Wake latency (`WAKE_CYCLES`=1), with a request first sampled in SLEEP at edge t:
  - `Enable` rises after t.
  - State enters ACTIVE and `Req_Ready` rises after t+1.
  - Accept at edge t+2; `Alu_Start` is high after t+2.
  - The gated clock edge at t+3 captures the op.
- Sleep latency: `Enable` falls after the edge ending the `IDLE_CYCLES`-th consecutive idle ACTIVE cycle.
- A request arriving in the cycle `Enable` falls re-enters WAKE on the next edge; no request is lost.

## Structure
- Shared package `alu_pwr_pkg`:
  - State enum `pwr_state_t` {SLEEP, WAKE, ACTIVE}.
  - Default constants `OP_W_DEF` and `CNT_W_DEF`.
- Sub-module `alu_pwr_sat_cnt` (parameter `W`; inputs `inc`, `clr`; output `q`), instantiated twice for `Gated_Cnt` and `Active_Cnt`.
- FSM, idle/wake counters and the issue register live in the top module.

## Test plan
- Reset, then 10 idle cycles → `Enable`=0, `Req_Ready`=0, `Gated_Cnt`=10, `Active_Cnt`=0.
- Single `Req_Valid` with `Req_Op`=4'h3 from SLEEP → `Enable` after 1 edge, `Req_Ready` after 2, `Alu_Start` pulse with `Alu_Op`=3 after 3; `Enable` returns to 0 exactly 8 idle cycles later.
- Four back-to-back requests with ops 1, 2, 3, 4 in ACTIVE → four consecutive `Alu_Start` pulses with matching `Alu_Op`; idle counter never expires.
- `Busy`=1 for 20 cycles after the last issue → stays ACTIVE; sleeps 8 cycles after `Busy` falls. Repeat with `Force_On` for the same result.
- `Req_Valid` in the same cycle the idle counter reaches 7 → accepted, state stays ACTIVE, `Enable` never drops.
- `Rst_n` asserted in WAKE with a pending request → immediate SLEEP, `Enable`=0, counters 0, no `Alu_Start`. `Cnt_Clr` pulse with `CNT_W`=4 saturated → counter returns to 0 and recounts.
